baopoco_status_collector: RTL and testbench

- Aggregates run-time health of the baopoco datapath in the user_clk domain into one 32-bit status word.
- Drives the user_data_in input of the baopoco_status software register, so the PPC reads it over OPB.
- Provides:
  - a sync heartbeat counter;
  - sync-period checking via a small arm/wait/run state machine;
  - a saturating overflow-event counter;
  - sticky per-source overflow flags, cleared from a software control bit.

---
 rtl/baopoco_status_pkg.sv | 27 ++
 rtl/baopoco_edge_det.sv | 21 ++
 rtl/baopoco_status_collector.sv | 126 ++++++++++++
 tb/tb_baopoco_status_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baopoco_status_pkg.sv
// Shared types and status-word field positions for the baopoco status collector.
package baopoco_status_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUNNING   = 2'd2
    } state_e;

    localparam int N_OVR         = 4;

    localparam int SYNC_CNT_LSB  = 20;
    localparam int SYNC_CNT_W    = 12;
    localparam int OVR_CNT_LSB   = 12;
    localparam int OVR_CNT_W     = 8;
    localparam int OVR_FLAGS_LSB = 8;
    localparam int SYNC_ERR_BIT  = 7;
    localparam int SYNC_SEEN_BIT = 6;
    localparam int STATE_LSB     = 4;
    localparam int PARITY_BIT    = 0;

    localparam int OVR_ADC   = 0;
    localparam int OVR_FFT   = 1;
    localparam int OVR_EQ    = 2;
    localparam int OVR_10GBE = 3;

endpackage

// File: rtl/baopoco_edge_det.sv
// Rising-edge detector; RST_VAL decides whether a level held high through reset counts as an edge.
module baopoco_edge_det #(
    parameter int   W       = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) d_q <= {W{RST_VAL}};
        else       d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/baopoco_status_collector.sv
// Collects sync heartbeat, sync-period health and overflow events into one 32-bit status word.
// Optional even parity on bit 0 when STATUS_PARITY_EN is defined.
module baopoco_status_collector
    import baopoco_status_pkg::*;
#(
    parameter int SYNC_PERIOD = 134217728,
    parameter int PERIOD_W    = 28
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             sync_in,
    input  logic [N_OVR-1:0] ovr_flags,
    input  logic             ctrl_arm,
    input  logic             ctrl_clr,
    output logic [31:0]      user_data_out,
    output logic             armed
);

    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SYNC_PERIOD - 1);

    logic             sync_rise, arm_rise, clr_rise;
    logic [N_OVR-1:0] ovr_rise;

    baopoco_edge_det #(.W(1), .RST_VAL(1'b0)) u_sync_ed (
        .clk_i(user_clk), .rst_i(user_rst), .d_i(sync_in), .rise_o(sync_rise));
    baopoco_edge_det #(.W(N_OVR), .RST_VAL(1'b0)) u_ovr_ed (
        .clk_i(user_clk), .rst_i(user_rst), .d_i(ovr_flags), .rise_o(ovr_rise));
    baopoco_edge_det #(.W(1), .RST_VAL(1'b1)) u_arm_ed (
        .clk_i(user_clk), .rst_i(user_rst), .d_i(ctrl_arm), .rise_o(arm_rise));
    baopoco_edge_det #(.W(1), .RST_VAL(1'b1)) u_clr_ed (
        .clk_i(user_clk), .rst_i(user_rst), .d_i(ctrl_clr), .rise_o(clr_rise));

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   per_q, per_d;
    logic [SYNC_CNT_W-1:0] sync_cnt_q, sync_cnt_d, sync_base;
    logic [OVR_CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d, ovr_base;
    logic [N_OVR-1:0]      sticky_q, sticky_d;
    logic                  err_q, err_d, seen_q, seen_d;
    logic                  err_set, seen_set;
    logic [31:0]           word_q, word_d;

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        err_set  = 1'b0;
        seen_set = 1'b0;
        if (arm_rise) begin
            // Arming overrides any same-cycle sync, so no period check happens.
            state_d = WAIT_SYNC;
            per_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_SYNC: begin
                    if (sync_rise) begin
                        state_d = RUNNING;
                        per_d   = '0;
                    end
                end
                RUNNING: begin
                    if (sync_rise) begin
                        per_d = '0;
                        if (per_q == PERIOD_LAST) seen_set = 1'b1;
                        else                      err_set  = 1'b1;
                    end else if (per_q == PERIOD_LAST) begin
                        err_set = 1'b1;
                        per_d   = '0;
                    end else begin
                        per_d = per_q + PERIOD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A clear edge zeroes the fields first; same-cycle events then land on top.
    always_comb begin
        sync_base  = clr_rise ? '0 : sync_cnt_q;
        ovr_base   = clr_rise ? '0 : ovr_cnt_q;
        sync_cnt_d = sync_base + SYNC_CNT_W'(sync_rise);
        ovr_cnt_d  = ovr_base + OVR_CNT_W'((|ovr_rise) && (ovr_base != {OVR_CNT_W{1'b1}}));
        sticky_d   = (clr_rise ? '0 : sticky_q) | ovr_flags;
        err_d      = (clr_rise ? 1'b0 : err_q) | err_set;
        seen_d     = (clr_rise ? 1'b0 : seen_q) | seen_set;

        word_d = '0;
        word_d[SYNC_CNT_LSB +: SYNC_CNT_W] = sync_cnt_d;
        word_d[OVR_CNT_LSB +: OVR_CNT_W]   = ovr_cnt_d;
        word_d[OVR_FLAGS_LSB +: N_OVR]     = sticky_d;
        word_d[SYNC_ERR_BIT]               = err_d;
        word_d[SYNC_SEEN_BIT]              = seen_d;
        word_d[STATE_LSB +: 2]             = state_d;
`ifdef STATUS_PARITY_EN
        word_d[PARITY_BIT]                 = ^word_d[31:1];
`else
        word_d[PARITY_BIT]                 = 1'b0;
`endif
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= IDLE;
            per_q      <= '0;
            sync_cnt_q <= '0;
            ovr_cnt_q  <= '0;
            sticky_q   <= '0;
            err_q      <= 1'b0;
            seen_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            sync_cnt_q <= sync_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
            sticky_q   <= sticky_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
            word_q     <= word_d;
        end
    end

    assign user_data_out = word_q;
    assign armed         = (state_q == WAIT_SYNC) || (state_q == RUNNING);

endmodule

// File: tb/tb_baopoco_status_collector.sv
// Randomized and directed bench for baopoco_status_collector with an in-bench reference model.
module tb_baopoco_status_collector;

    localparam int P = 8;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic        sync_in = 1'b0, ctrl_arm = 1'b0, ctrl_clr = 1'b0;
    logic [3:0]  ovr_flags = 4'b0;
    logic [31:0] user_data_out;
    logic        armed;

    int n_chk = 0;
    int n_fail = 0;

    baopoco_status_collector #(.SYNC_PERIOD(P), .PERIOD_W(4)) dut (
        .user_clk(user_clk), .user_rst(user_rst), .sync_in(sync_in),
        .ovr_flags(ovr_flags), .ctrl_arm(ctrl_arm), .ctrl_clr(ctrl_clr),
        .user_data_out(user_data_out), .armed(armed));

    always #5 user_clk = ~user_clk;

    // Reference model: state 0 idle, 1 waiting for sync, 2 running.
    int       m_st, m_per, m_sc, m_oc;
    bit [3:0] m_stk, p_ovr;
    bit       m_err, m_seen, p_sync, p_arm, p_clr;

    function automatic logic [31:0] m_word();
        logic [31:0] w;
        w = {m_sc[11:0], m_oc[7:0], m_stk, m_err, m_seen, m_st[1:0], 4'b0000};
`ifdef STATUS_PARITY_EN
        w[0] = ^w[31:1];
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_st = 0; m_per = 0; m_sc = 0; m_oc = 0; m_stk = 0; m_err = 0; m_seen = 0;
        p_sync = 0; p_ovr = 0; p_arm = 1; p_clr = 1;
    endtask

    task automatic model_step();
        bit sr, ar, cr;
        bit [3:0] orr;
        sr  = sync_in && !p_sync;
        ar  = ctrl_arm && !p_arm;
        cr  = ctrl_clr && !p_clr;
        orr = ovr_flags & ~p_ovr;
        if (cr) begin m_sc = 0; m_oc = 0; m_stk = 0; m_err = 0; m_seen = 0; end
        if (sr) m_sc = (m_sc + 1) % 4096;
        if (orr != 0 && m_oc < 255) m_oc++;
        m_stk |= ovr_flags;
        if (ar) begin
            m_st = 1; m_per = 0;
        end else if (m_st == 1) begin
            if (sr) begin m_st = 2; m_per = 0; end
        end else if (m_st == 2) begin
            if (sr) begin
                if (m_per == P - 1) m_seen = 1; else m_err = 1;
                m_per = 0;
            end else if (m_per == P - 1) begin
                m_err = 1; m_per = 0;
            end else begin
                m_per++;
            end
        end
        p_sync = sync_in; p_arm = ctrl_arm; p_clr = ctrl_clr; p_ovr = ovr_flags;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit s, input bit [3:0] o, input bit a, input bit c);
        sync_in = s; ovr_flags = o; ctrl_arm = a; ctrl_clr = c;
        @(posedge user_clk);
        model_step();
        @(negedge user_clk);
    endtask

    task automatic do_reset();
        sync_in = 0; ovr_flags = 0; ctrl_arm = 0; ctrl_clr = 0;
        user_rst = 1;
        repeat (3) @(negedge user_clk);
        model_reset();
        user_rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) cycle(0, 0, 0, 0);
        n_chk++;
        if (user_data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_word: got %h expected %h", user_data_out, 32'h0);
        end
        n_chk++;
        if (armed !== 1'b0) begin
            n_fail++; $display("FAIL reset_armed: got %b expected 0", armed);
        end
    endtask

    task automatic test_period_ok();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        n_chk++;
        if (armed !== 1'b1 || user_data_out[5:4] !== 2'd1) begin
            n_fail++; $display("FAIL arm_wait: got armed=%b state=%0d expected 1/1", armed, user_data_out[5:4]);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0);
            if (k < 2) repeat (7) cycle(0, 0, 0, 0);
        end
        n_chk++;
        if (user_data_out[5:4] !== 2'd2 || user_data_out[7] !== 1'b0 || user_data_out[6] !== 1'b1) begin
            n_fail++; $display("FAIL period_ok_flags: got state=%0d err=%b seen=%b expected 2/0/1",
                               user_data_out[5:4], user_data_out[7], user_data_out[6]);
        end
        n_chk++;
        if (user_data_out[31:20] !== 12'd3) begin
            n_fail++; $display("FAIL period_ok_sync_count: got %0d expected 3", user_data_out[31:20]);
        end
        n_chk++;
        if (user_data_out !== m_word()) begin
            n_fail++; $display("FAIL period_ok_word: got %h expected %h", user_data_out, m_word());
        end
    endtask

    task automatic test_period_err();
        cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        n_chk++;
        if (user_data_out[7] !== 1'b1) begin
            n_fail++; $display("FAIL short_period_err: got %b expected 1", user_data_out[7]);
        end
        repeat (8) cycle(0, 0, 0, 0);
        n_chk++;
        if (user_data_out[7] !== 1'b1 || user_data_out[5:4] !== 2'd2) begin
            n_fail++; $display("FAIL missing_sync: got err=%b state=%0d expected 1/2", user_data_out[7], user_data_out[5:4]);
        end
        n_chk++;
        if (user_data_out !== m_word()) begin
            n_fail++; $display("FAIL period_err_word: got %h expected %h", user_data_out, m_word());
        end
    endtask

    task automatic test_ovr();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 4'b0101, 0, 0);
        cycle(0, 4'b0000, 0, 0);
        cycle(0, 4'b0001, 0, 0);
        cycle(0, 4'b0000, 0, 0);
        cycle(0, 4'b0001, 0, 0);
        cycle(0, 4'b0000, 0, 0);
        n_chk++;
        if (user_data_out[19:12] !== 8'd3 || user_data_out[11:8] !== 4'b0101) begin
            n_fail++; $display("FAIL ovr_count_flags: got cnt=%0d flags=%b expected 3/0101",
                               user_data_out[19:12], user_data_out[11:8]);
        end
        n_chk++;
        if (user_data_out !== m_word()) begin
            n_fail++; $display("FAIL ovr_word: got %h expected %h", user_data_out, m_word());
        end
    endtask

    task automatic test_ovr_sat();
        repeat (300) begin
            cycle(0, 4'b0010, 0, 0);
            cycle(0, 4'b0000, 0, 0);
        end
        n_chk++;
        if (user_data_out[19:12] !== 8'd255) begin
            n_fail++; $display("FAIL ovr_saturate: got %0d expected 255", user_data_out[19:12]);
        end
        cycle(0, 4'b0100, 0, 1);
        n_chk++;
        if (user_data_out[19:12] !== 8'd1 || user_data_out[11:8] !== 4'b0100) begin
            n_fail++; $display("FAIL clr_with_event: got cnt=%0d flags=%b expected 1/0100",
                               user_data_out[19:12], user_data_out[11:8]);
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0);
        n_chk++;
        if (armed !== 1'b0 || user_data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_run: got armed=%b word=%h expected 0/0", armed, user_data_out);
        end
        cycle(1, 0, 0, 0);
        repeat (P + 2) cycle(0, 0, 0, 0);
        n_chk++;
        if (user_data_out[31:20] !== 12'd1 || user_data_out[7:4] !== 4'h0) begin
            n_fail++; $display("FAIL sync_after_reset: got cnt=%0d bits7_4=%h expected 1/0",
                               user_data_out[31:20], user_data_out[7:4]);
        end
    endtask

    task automatic test_parity();
        logic [31:0] exp_w;
`ifdef STATUS_PARITY_EN
        exp_w = 32'h0010_0001;
`else
        exp_w = 32'h0010_0000;
`endif
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        n_chk++;
        if (user_data_out !== exp_w) begin
            n_fail++; $display("FAIL parity_word: got %h expected %h", user_data_out, exp_w);
        end
    endtask

    task automatic test_random();
        bit s, a, c;
        bit [3:0] o;
        a = 0; c = 0;
        for (int blk = 0; blk < 30; blk++) begin
            bit periodic;
            periodic = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 100; i++) begin
                if (periodic) s = (i % P == 0) || ((i % P == 1) && $urandom_range(0, 1) == 1);
                else          s = ($urandom_range(0, 5) == 0);
                for (int b = 0; b < 4; b++) o[b] = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 40) == 0) a = ~a;
                if ($urandom_range(0, 60) == 0) c = ~c;
                cycle(s, o, a, c);
                n_chk++;
                if (user_data_out !== m_word()) begin
                    n_fail++; $display("FAIL random_word: got %h expected %h", user_data_out, m_word());
                end
                n_chk++;
                if (armed !== (m_st == 1 || m_st == 2)) begin
                    n_fail++; $display("FAIL random_armed: got %b expected %b", armed, (m_st == 1 || m_st == 2));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge user_clk);
        test_reset();
        test_period_ok();
        test_period_err();
        test_ovr();
        test_ovr_sat();
        test_reset_mid_run();
        test_parity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
